// File: rtl/video_pkg.sv
// Shared video definitions: pixel width, default fill colour and the
// line feeder state encoding.
package video_pkg;

    localparam int unsigned RGB_W      = 24;
    localparam int unsigned LINE_IDX_W = 12;
    localparam int unsigned UF_CNT_W   = 16;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t FILL_RGB_DEFAULT = 24'h000000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear, occupancy count and registered
// read data that only updates on a successful pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr    <= rptr + AW'(1);
                rd_data <= mem[rptr];
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && !clr && do_push) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: rtl/video_line_feeder.sv
// Line-based pixel supply for the video timing driver: requests lines from
// the DDR read engine, buffers them, and pops one pixel per data_req.
module video_line_feeder
    import video_pkg::*;
#(
    parameter int unsigned H_DISP     = 1280,
    parameter int unsigned V_DISP     = 720,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter rgb_t        FILL_RGB   = FILL_RGB_DEFAULT
) (
    input  logic                  pixel_clk,
    input  logic                  sys_rst,
    input  logic                  video_vs,
    input  logic                  data_req,
    output logic [RGB_W-1:0]      pixel_data,
    output logic                  line_req,
    output logic [LINE_IDX_W-1:0] line_idx,
    input  logic                  line_ack,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [RGB_W-1:0]      s_data,
    output logic                  underflow,
    output logic [UF_CNT_W-1:0]   underflow_cnt
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    feeder_state_e         state_q, state_d;
    logic                  vs_q;
    logic                  fill_q, fill_d;
    logic [CNT_W-1:0]      outstanding_q, outstanding_d;
    logic [CNT_W-1:0]      out_tmp;
    logic                  line_req_d;
    logic [LINE_IDX_W-1:0] line_idx_d;
    logic                  s_ready_d;
    logic                  underflow_d;
    logic [UF_CNT_W-1:0]   uf_cnt_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      count_nxt;
    logic [RGB_W-1:0]      fifo_rd;
    logic                  fifo_push, fifo_pop, fifo_clr;
    logic                  frame_start, run_like, ack, fits;

    assign frame_start = vs_q && !video_vs;
    assign run_like    = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign ack         = (state_q == ST_RUN) && line_req && line_ack;
    assign fifo_clr    = (state_q == ST_FLUSH);
    assign fifo_push   = run_like && s_valid && s_ready;
    assign fifo_pop    = run_like && data_req && (fifo_count != '0);
    assign count_nxt   = fifo_clr ? '0 : fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    assign fits        = (SUM_W'(fifo_count) + SUM_W'(outstanding_q) + SUM_W'(H_DISP))
                         <= SUM_W'(FIFO_DEPTH);

    // Registered FIFO head or fill colour, selected by a registered flag.
    assign pixel_data  = fill_q ? FILL_RGB : fifo_rd;

    sync_fifo #(
        .WIDTH (RGB_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (pixel_clk),
        .rst     (sys_rst),
        .clr     (fifo_clr),
        .push    (fifo_push),
        .wr_data (s_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .count   (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        line_req_d    = line_req;
        line_idx_d    = line_idx;
        s_ready_d     = s_ready;
        underflow_d   = underflow;
        uf_cnt_d      = underflow_cnt;
        fill_d        = fill_q;

        if (data_req) begin
            fill_d = !fifo_pop;
            if (run_like && (fifo_count == '0)) begin
                underflow_d = 1'b1;
                if (underflow_cnt != '1) begin
                    uf_cnt_d = underflow_cnt + UF_CNT_W'(1);
                end
            end
        end

        // Outstanding words: add a line on ack, retire one per accepted beat.
        out_tmp = outstanding_q + (ack ? CNT_W'(H_DISP) : '0);
        if (fifo_push && (out_tmp != '0)) begin
            out_tmp = out_tmp - CNT_W'(1);
        end
        outstanding_d = out_tmp;

        case (state_q)
            ST_IDLE: begin
                line_req_d = 1'b0;
            end
            ST_FLUSH: begin
                state_d       = ST_RUN;
                line_req_d    = 1'b1;
                line_idx_d    = '0;
                outstanding_d = '0;
                underflow_d   = 1'b0;
                uf_cnt_d      = '0;
            end
            ST_RUN: begin
                if (ack) begin
                    line_req_d = 1'b0;
                    line_idx_d = line_idx + LINE_IDX_W'(1);
                    if (line_idx == LINE_IDX_W'(V_DISP - 1)) begin
                        state_d = ST_DONE;
                    end
                end else if (!line_req) begin
                    line_req_d = fits;
                end
            end
            ST_DONE: begin
                line_req_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (frame_start) begin
            state_d    = ST_FLUSH;
            line_req_d = 1'b0;
        end

        case (state_d)
            ST_IDLE:  s_ready_d = 1'b1;
            ST_FLUSH: s_ready_d = 1'b0;
            default:  s_ready_d = (count_nxt < CNT_W'(FIFO_DEPTH));
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_q       <= ST_IDLE;
            vs_q          <= 1'b0;
            fill_q        <= 1'b0;
            outstanding_q <= '0;
            line_req      <= 1'b0;
            line_idx      <= '0;
            s_ready       <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= video_vs;
            fill_q        <= fill_d;
            outstanding_q <= outstanding_d;
            line_req      <= line_req_d;
            line_idx      <= line_idx_d;
            s_ready       <= s_ready_d;
            underflow     <= underflow_d;
            underflow_cnt <= uf_cnt_d;
        end
    end

endmodule

// File: tb/tb_video_line_feeder.sv
// Scoreboard bench for video_line_feeder with a small DDR engine model;
// geometry is scaled down so full frames fit in a short run.
module tb_video_line_feeder;
    import video_pkg::*;

    localparam int unsigned H    = 40;
    localparam int unsigned V    = 48;
    localparam int unsigned D    = 64;
    localparam logic [23:0] FILL = 24'hC0FFEE;

    logic        pixel_clk = 1'b0;
    logic        sys_rst;
    logic        video_vs;
    logic        data_req;
    logic [23:0] pixel_data;
    logic        line_req;
    logic [11:0] line_idx;
    logic        line_ack;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        underflow;
    logic [15:0] underflow_cnt;

    always #5 pixel_clk = ~pixel_clk;

    video_line_feeder #(
        .H_DISP     (H),
        .V_DISP     (V),
        .FIFO_DEPTH (D),
        .FILL_RGB   (FILL)
    ) dut (
        .pixel_clk     (pixel_clk),
        .sys_rst       (sys_rst),
        .video_vs      (video_vs),
        .data_req      (data_req),
        .pixel_data    (pixel_data),
        .line_req      (line_req),
        .line_idx      (line_idx),
        .line_ack      (line_ack),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] exp_q[$];
    logic [23:0] acc_vals[$];
    logic [23:0] beat_q[$];
    bit          ack_en  = 1'b0;
    bit          data_en = 1'b0;
    bit          in_run  = 1'b0;
    int          n_acks  = 0;
    int          exp_uf  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // DDR engine model: acks after 5 request cycles, then streams the line.
    initial begin : ddr
        bit          acc, ackd, lr;
        logic [11:0] idx;
        int          wait_cnt;
        wait_cnt = 0;
        line_ack = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        forever begin
            @(posedge pixel_clk);
            acc  = s_valid && s_ready && !sys_rst;
            ackd = line_req && line_ack && !sys_rst;
            lr   = line_req;
            idx  = line_idx;
            #1;
            if (acc) acc_vals.push_back(beat_q.pop_front());
            if (ackd) begin
                n_acks++;
                for (int k = 0; k < int'(H); k++) beat_q.push_back(24'(int'(idx) * int'(H) + k));
            end
            line_ack = 1'b0;
            if (ackd || !lr || !ack_en) begin
                wait_cnt = 0;
            end else begin
                wait_cnt++;
                if (wait_cnt == 5) line_ack = 1'b1;
            end
            s_valid = data_en && (beat_q.size() > 0);
            s_data  = s_valid ? beat_q[0] : 24'h0;
        end
    end

    // Pixel monitor: every data_req owes one scoreboard entry on the next cycle.
    initial begin : monitor
        bit          r;
        logic [23:0] e;
        forever begin
            @(posedge pixel_clk);
            r = data_req && !sys_rst;
            @(negedge pixel_clk);
            if (r) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pixel_unexpected: got 0x%0h with no expected entry", pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'(pixel_data), 32'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic issue_req();
        data_req = 1'b1;
        if (acc_vals.size() > 0) begin
            exp_q.push_back(acc_vals.pop_front());
        end else begin
            exp_q.push_back(FILL);
            if (in_run) exp_uf++;
        end
    endtask

    task automatic frame_start();
        data_en  = 1'b0;
        ack_en   = 1'b0;
        data_req = 1'b0;
        @(negedge pixel_clk);
        video_vs = 1'b0;
        beat_q.delete();
        acc_vals.delete();
        n_acks = 0;
        exp_uf = 0;
        in_run = 1'b1;
        @(negedge pixel_clk);
        check("flush_line_req", 32'(line_req), 32'd0);
        check("flush_s_ready", 32'(s_ready), 32'd0);
        video_vs = 1'b1;
        @(negedge pixel_clk);
        check("run_line_req", 32'(line_req), 32'd1);
        check("run_line_idx", 32'(line_idx), 32'd0);
        check("run_underflow", 32'(underflow), 32'd0);
        check("run_uf_cnt", 32'(underflow_cnt), 32'd0);
    endtask

    task automatic pump_until(input int target, input bit need_req, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge pixel_clk);
            if (int'(line_idx) == target && (!need_req || line_req)) begin
                ok = 1'b1;
                break;
            end
            if (acc_vals.size() > 0) issue_req();
            else data_req = 1'b0;
        end
        data_req = 1'b0;
    endtask

    initial begin : main
        bit ok;
        int hits;
        sys_rst  = 1'b1;
        video_vs = 1'b1;
        data_req = 1'b1;

        // Reset with data_req held high.
        repeat (3) @(negedge pixel_clk);
        check("rst_pixel", 32'(pixel_data), 32'd0);
        check("rst_line_req", 32'(line_req), 32'd0);
        check("rst_line_idx", 32'(line_idx), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        sys_rst  = 1'b0;
        data_req = 1'b0;

        // IDLE: stream sink open, fill returned but not counted.
        @(negedge pixel_clk);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        issue_req();
        @(negedge pixel_clk);
        data_req = 1'b0;
        @(negedge pixel_clk);
        check("idle_uf_cnt", 32'(underflow_cnt), 32'd0);
        check("idle_underflow", 32'(underflow), 32'd0);

        // Nominal frame with prefetch limit.
        frame_start();
        ack_en  = 1'b1;
        data_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge pixel_clk);
            if (acc_vals.size() == H) begin
                ok = 1'b1;
                break;
            end
        end
        check("line0_received", 32'(ok), 32'd1);
        repeat (20) @(negedge pixel_clk);
        check("prefetch_acks", 32'(n_acks), 32'd1);
        check("prefetch_line_req", 32'(line_req), 32'd0);
        check("prefetch_line_idx", 32'(line_idx), 32'd1);
        check("prefetch_buffered", 32'(acc_vals.size()), 32'(H));
        for (int i = 0; i < 15; i++) begin
            @(negedge pixel_clk);
            issue_req();
        end
        @(negedge pixel_clk);
        data_req = 1'b0;
        repeat (8) @(negedge pixel_clk);
        check("pop15_line_req", 32'(line_req), 32'd0);
        check("pop15_acks", 32'(n_acks), 32'd1);
        issue_req();
        @(negedge pixel_clk);
        data_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pixel_clk);
            if (line_req) begin
                ok = 1'b1;
                break;
            end
        end
        check("pop16_line_req", 32'(ok), 32'd1);
        for (int i = 0; i < 24; i++) begin
            @(negedge pixel_clk);
            issue_req();
        end
        @(negedge pixel_clk);
        data_req = 1'b0;
        @(negedge pixel_clk);
        check("nominal_underflow", 32'(underflow), 32'd0);
        check("nominal_uf_cnt", 32'(underflow_cnt), 32'd0);

        // Underflow with no stream data.
        frame_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge pixel_clk);
            issue_req();
        end
        @(negedge pixel_clk);
        data_req = 1'b0;
        @(negedge pixel_clk);
        check("uf_flag", 32'(underflow), 32'd1);
        check("uf_cnt", 32'(underflow_cnt), 32'd10);
        check("uf_cnt_model", 32'(underflow_cnt), 32'(exp_uf));
        frame_start();

        // Mid-frame restart while line 37 is pending.
        ack_en  = 1'b1;
        data_en = 1'b1;
        pump_until(37, 1'b0, 4000, ok);
        check("reach_line37", 32'(ok), 32'd1);
        ack_en = 1'b0;
        pump_until(37, 1'b1, 400, ok);
        check("line37_req", 32'(ok), 32'd1);
        repeat (10) @(negedge pixel_clk);
        check("pending_req", 32'(line_req), 32'd1);
        check("pending_idx", 32'(line_idx), 32'd37);
        frame_start();
        @(negedge pixel_clk);
        issue_req();
        @(negedge pixel_clk);
        data_req = 1'b0;
        @(negedge pixel_clk);
        check("restart_empty_uf", 32'(underflow_cnt), 32'd1);

        // Run the whole frame through to the last line.
        ack_en  = 1'b1;
        data_en = 1'b1;
        pump_until(int'(V), 1'b0, 6000, ok);
        check("reach_done", 32'(ok), 32'd1);
        hits = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge pixel_clk);
            if (line_req) hits++;
            if (acc_vals.size() > 0) issue_req();
            else data_req = 1'b0;
        end
        data_req = 1'b0;
        check("done_no_req", 32'(hits), 32'd0);
        check("done_line_idx", 32'(line_idx), 32'(V));
        check("done_acks", 32'(n_acks), 32'(V));
        check("done_uf_cnt", 32'(underflow_cnt), 32'(exp_uf));
        frame_start();

        repeat (5) @(negedge pixel_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
